// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a first-word-fall-through RX FIFO with sticky error flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose the parity_err flag.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overrun,
    output logic                          frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    output logic                          busy
);
    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0]    FULL     = CW'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    logic             rx_meta_q, rx_s_q, armed_q;
    logic [1:0]       fill_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic             bit_tick, push_req, frame_set, par_bad;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d, par_set, parity_q;
`endif

    // Two-flop synchronizer. armed_q stays low until a real high level has been
    // seen, so a line held low through reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            fill_q    <= '0;
            armed_q   <= 1'b0;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
            fill_q    <= {fill_q[0], 1'b1};
            armed_q   <= armed_q | (fill_q[1] & rx_s_q);
        end
    end

    assign bit_tick = (cnt_q == CNT_MAX);
`ifdef UART_RX_PARITY_EN
    assign par_bad = par_bad_q;
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = bit_tick ? '0 : cnt_q + 1'b1;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        par_set   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (armed_q && !rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = CNT_HALF;
                end
            end
            S_START: if (bit_tick) begin
                state_d = rx_s_q ? S_IDLE : S_DATA;
                bit_d   = '0;
            end
            S_DATA: if (bit_tick) begin
                shreg_d = {rx_s_q, shreg_q[DATA_W-1:1]};
                bit_d   = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                if (bit_q == 3'd7) state_d = S_PARITY;
`else
                if (bit_q == 3'd7) state_d = S_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (bit_tick) begin
                par_set   = ^{shreg_q, rx_s_q};
                par_bad_d = par_set;
                state_d   = S_STOP;
            end
`endif
            // Leaving at mid-stop-bit gives half a bit of slack for back-to-back frames.
            S_STOP: if (bit_tick) begin
                if (rx_s_q) begin
                    push_req = !par_bad;
                    state_d  = S_IDLE;
                end else begin
                    frame_set = 1'b1;
                    state_d   = S_BREAK;
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              pop, full, push_ok, overrun_q, frame_q;

    assign pop     = rd_en && (count_q != '0);
    assign full    = (count_q == FULL);
    assign push_ok = push_req && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_q + CW'(push_ok) - CW'(pop);
            // A new error event in the same cycle as err_clr keeps the flag set.
            overrun_q <= (push_req && full && !pop) | (overrun_q & ~err_clr);
            frame_q   <= frame_set | (frame_q & ~err_clr);
`ifdef UART_RX_PARITY_EN
            parity_q  <= par_set | (parity_q & ~err_clr);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= shreg_q;
    end

    assign rx_valid  = (count_q != '0);
    assign rd_data   = rx_valid ? mem_q[rd_ptr_q] : '0;
    assign rx_count  = count_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_q;
    assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are modelled as bytes entering a bounded
// queue; a monitor compares every popped byte against that queue.
module tb_uart_rx_fifo;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    // Stop-bit centre: two sync flops, one cycle to see the edge, half a bit to the
    // start-bit centre, then one full bit per data/parity/stop bit.
    localparam int SAMPLE = 3 + (CPB - CPB / 2) + NB * CPB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_rx = 1'b0;
    logic rd_en = 1'b0;
    logic err_clr = 1'b0;
    logic [7:0] rd_data;
    logic rx_valid, overrun, frame_err, busy;
    logic [$clog2(DEPTH):0] rx_count;
`ifdef UART_RX_PARITY_EN
    logic parity_err;
    logic exp_perr = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];
    logic [7:0] mon_exp;
    logic exp_ovr = 1'b0;
    logic exp_ferr = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .rd_en(rd_en), .err_clr(err_clr),
        .rd_data(rd_data), .rx_valid(rx_valid), .rx_count(rx_count),
        .overrun(overrun), .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy(busy)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every accepted pop must deliver the oldest byte the model holds.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && rd_en && rx_valid) begin
                if (sb.size() == 0) begin
                    chk("pop_without_expected_byte", int'(rd_data), -1);
                end else begin
                    mon_exp = sb.pop_front();
                    chk("pop_data", int'(rd_data), int'(mon_exp));
                end
            end
        end
    end

    task automatic check_flags(input string tag);
        chk({tag, "_overrun"}, int'(overrun), int'(exp_ovr));
        chk({tag, "_frame_err"}, int'(frame_err), int'(exp_ferr));
`ifdef UART_RX_PARITY_EN
        chk({tag, "_parity_err"}, int'(parity_err), int'(exp_perr));
`endif
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic pflip,
                              input logic do_pop, input logic do_clr);
        logic [11:0] fr;
        logic pbad;
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = b;
`ifdef UART_RX_PARITY_EN
        fr[9]  = (^b) ^ pflip;
        fr[10] = stop_b;
`else
        fr[9] = stop_b;
`endif
        pbad = pflip;
        for (int c = 0; c < (NB + 1) * CPB; c++) begin
            uart_rx = fr[c / CPB];
            if (c == SAMPLE - 1) begin
                chk("count_before_stop", int'(rx_count), sb.size());
                rd_en = do_pop;
                err_clr = do_clr;
            end
            if (c == SAMPLE) begin
                rd_en = 1'b0;
                err_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
                if (pbad) exp_perr = 1'b1;
                if (do_clr) exp_perr = 1'b0;
`endif
                if (do_clr) begin
                    exp_ovr = 1'b0;
                    exp_ferr = 1'b0;
                end
                if (!stop_b) exp_ferr = 1'b1;
                else if (!pbad) begin
                    if (sb.size() < DEPTH) sb.push_back(b);
                    else exp_ovr = 1'b1;
                end
                chk("count_after_stop", int'(rx_count), sb.size());
                chk("valid_after_stop", int'(rx_valid), int'(sb.size() != 0));
                check_flags("after_stop");
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && rx_valid; i++) begin
            rd_en = 1'b1;
            @(posedge clk);
            #1;
        end
        rd_en = 1'b0;
        chk("drain_model_left", sb.size(), 0);
        chk("empty_valid", int'(rx_valid), 0);
        chk("empty_rd_data", int'(rd_data), 0);
        chk("empty_count", int'(rx_count), 0);
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
        exp_perr = 1'b0;
`endif
        check_flags("after_clear");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic bad, flip;
        cyc(3);
        rst = 1'b1;
        chk("reset_valid", int'(rx_valid), 0);
        chk("reset_rd_data", int'(rd_data), 0);
        chk("reset_count", int'(rx_count), 0);
        chk("reset_busy", int'(busy), 0);
        check_flags("reset");
        cyc(10 * CPB);
        chk("held_low_busy", int'(busy), 0);
        chk("held_low_frame_err", int'(frame_err), 0);
        uart_rx = 1'b1;
        cyc(4);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("a5_rd_data", int'(rd_data), 8'hA5);
        drain();

        uart_rx = 1'b0;
        cyc(4);
        uart_rx = 1'b1;
        cyc(2);
        chk("glitch_busy_mid", int'(busy), 1);
        cyc(CPB);
        chk("glitch_busy_end", int'(busy), 0);
        chk("glitch_count", int'(rx_count), 0);
        check_flags("glitch");

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(40 * CPB);
        chk("break_frame_err", int'(frame_err), 1);
        chk("break_count", int'(rx_count), 0);
        chk("break_busy", int'(busy), 1);
        clear_errors();
        cyc(10 * CPB);
        chk("break_no_repeat", int'(frame_err), 0);
        uart_rx = 1'b1;
        cyc(4);
        chk("break_release_busy", int'(busy), 0);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("after_break_rd_data", int'(rd_data), 8'h55);
        drain();

        send_frame(8'h99, 1'b0, 1'b0, 1'b0, 1'b1);
        uart_rx = 1'b1;
        cyc(4);
        clear_errors();

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("full_count", int'(rx_count), DEPTH);
        chk("full_overrun", int'(overrun), 1);
        drain();
        clear_errors();

        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h06, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("pushpop_count", int'(rx_count), DEPTH);
        chk("pushpop_overrun", int'(overrun), 0);
        drain();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("parity_good_err", int'(parity_err), 0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("parity_bad_err", int'(parity_err), 1);
        chk("parity_bad_count", int'(rx_count), 1);
        drain();
        clear_errors();
`endif

        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 5 * CPB; c++) begin
            uart_rx = (c < CPB) ? 1'b0 : c[4];
            cyc(1);
        end
        rst = 1'b0;
        sb.delete();
        cyc(2);
        chk("midreset_count", int'(rx_count), 0);
        chk("midreset_busy", int'(busy), 0);
        rst = 1'b1;
        uart_rx = 1'b1;
        cyc(4);

        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
`ifdef UART_RX_PARITY_EN
            flip = ($urandom_range(0, 5) == 0);
`else
            flip = 1'b0;
`endif
            send_frame(b, !bad, flip, 1'b0, 1'b0);
            if (bad) begin
                uart_rx = 1'b1;
                cyc(4);
            end else begin
                cyc($urandom_range(0, CPB));
            end
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();
        clear_errors();

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
